axi_r_resp_channel: RTL

AXI_R_RESP_CHANNEL -- requirements
Module: axi_r_resp_channel

---
 rtl/axi_r_resp_channel.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_r_resp_channel.sv
// Purpose: AXI read-response channel; buffers MC read words and descriptors, skips ignored words, emits R beats.
// Latency: MC word in cycle 0 appears on rvalid in cycle 2 (data FIFO write, then output-slot load).
// Backpressure: rready stalls the output slot; MC data has none, so rd_cmd_ok reserves FIFO space up front.
module axi_r_resp_channel #(
  parameter int C_ID_WIDTH      = 4,
  parameter int C_DATA_WIDTH    = 32,
  parameter int C_BEATS_PER_CMD = 2,
  parameter int C_TRANS_DEPTH   = 4,
  parameter int C_DATA_DEPTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    t_push,
  input  logic [C_ID_WIDTH-1:0]   t_arid,
  input  logic [7:0]              t_arlen,
  input  logic                    t_ignore_begin,
  input  logic                    t_ignore_end,
  output logic                    t_full,
  input  logic                    cmd_issue,
  output logic                    rd_cmd_ok,
  input  logic                    mc_rd_valid,
  input  logic [C_DATA_WIDTH-1:0] mc_rd_data,
  output logic [C_ID_WIDTH-1:0]   rid,
  output logic [C_DATA_WIDTH-1:0] rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    overflow_err
);

  localparam int TAW = $clog2(C_TRANS_DEPTH);
  localparam int DAW = $clog2(C_DATA_DEPTH);
  localparam int PW  = DAW + 3;
  localparam logic [TAW:0]   LP_TFULL = (TAW+1)'(C_TRANS_DEPTH);
  localparam logic [TAW:0]   LP_TONE  = (TAW+1)'(1);
  localparam logic [DAW:0]   LP_DFULL = (DAW+1)'(C_DATA_DEPTH);
  localparam logic [PW-1:0]  LP_DEPTH = PW'(C_DATA_DEPTH);
  localparam logic [PW-1:0]  LP_BEATS = PW'(C_BEATS_PER_CMD);

  typedef struct packed {
    logic [C_ID_WIDTH-1:0] id;
    logic [7:0]            len;
    logic                  ib;
    logic                  ie;
  } desc_t;

  typedef enum logic [1:0] {IDLE, SKIP_BEGIN, STREAM, SKIP_END} state_t;

  desc_t                   r_tmem [C_TRANS_DEPTH];
  logic [TAW-1:0]          r_twr, r_trd;
  logic [TAW:0]            r_tcnt;
  logic [C_DATA_WIDTH-1:0] r_dmem [C_DATA_DEPTH];
  logic [DAW-1:0]          r_dwr, r_drd;
  logic [DAW:0]            r_dcnt;
  logic [PW-1:0]           r_pend;
  logic [7:0]              r_beat_cnt;
  state_t                  r_state, w_state_nxt, w_follow;
  logic                    r_rvalid, r_rlast, r_ovf;
  logic [C_ID_WIDTH-1:0]   r_rid;
  logic [C_DATA_WIDTH-1:0] r_rdata;

  logic           w_tpush, w_tpop, w_dwr, w_dpop, w_beat, w_last;
  logic           w_dempty, w_dfull, w_slot_free;
  logic [TAW-1:0] w_trd_nxt;
  desc_t          w_head, w_next;
  logic [PW-1:0]  w_pend_sum, w_used;

  assign t_full      = (r_tcnt == LP_TFULL);
  assign w_tpush     = t_push && !t_full;
  assign w_trd_nxt   = r_trd + TAW'(1);
  assign w_head      = r_tmem[r_trd];
  assign w_next      = r_tmem[w_trd_nxt];
  assign w_dempty    = (r_dcnt == '0);
  assign w_dfull     = (r_dcnt == LP_DFULL);
  assign w_dwr       = mc_rd_valid && (!w_dfull || w_dpop);
  assign w_slot_free = !r_rvalid || rready;
  assign w_last      = (r_beat_cnt == w_head.len);
  assign w_pend_sum  = r_pend + (cmd_issue ? LP_BEATS : '0);
  assign w_used      = PW'(r_dcnt) + r_pend + LP_BEATS;
  assign rd_cmd_ok   = (w_used <= LP_DEPTH);

  // Transaction descriptor storage (no reset needed on the array itself)
  always_ff @(posedge clk) begin
    if (w_tpush) r_tmem[r_twr] <= '{id: t_arid, len: t_arlen, ib: t_ignore_begin, ie: t_ignore_end};
  end

  // Transaction FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_twr  <= '0;
      r_trd  <= '0;
      r_tcnt <= '0;
    end else begin
      if (w_tpush) r_twr <= r_twr + TAW'(1);
      if (w_tpop)  r_trd <= w_trd_nxt;
      r_tcnt <= r_tcnt + (w_tpush ? LP_TONE : '0) - (w_tpop ? LP_TONE : '0);
    end
  end

  // Data word storage
  always_ff @(posedge clk) begin
    if (w_dwr) r_dmem[r_dwr] <= mc_rd_data;
  end

  // Data FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dwr  <= '0;
      r_drd  <= '0;
      r_dcnt <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_dwr)  r_dwr <= r_dwr + DAW'(1);
      if (w_dpop) r_drd <= r_drd + DAW'(1);
      r_dcnt <= r_dcnt + (w_dwr ? (DAW+1)'(1) : '0) - (w_dpop ? (DAW+1)'(1) : '0);
      if (mc_rd_valid && !w_dwr) r_ovf <= 1'b1;
    end
  end

  // Outstanding words owed by the MC; never underflows on unsolicited data
  always_ff @(posedge clk) begin
    if (reset)                                r_pend <= '0;
    else if (mc_rd_valid && w_pend_sum != '0) r_pend <= w_pend_sum - PW'(1);
    else                                      r_pend <= w_pend_sum;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and FIFO pops; a finished transaction jumps straight into the next descriptor
  always_comb begin
    w_state_nxt = r_state;
    w_dpop      = 1'b0;
    w_tpop      = 1'b0;
    w_beat      = 1'b0;
    w_follow    = IDLE;
    if (r_tcnt > LP_TONE) w_follow = w_next.ib ? SKIP_BEGIN : STREAM;
    case (r_state)
      IDLE: begin
        if (r_tcnt != '0) w_state_nxt = w_head.ib ? SKIP_BEGIN : STREAM;
      end
      SKIP_BEGIN: begin
        if (!w_dempty) begin
          w_dpop      = 1'b1;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (!w_dempty && w_slot_free) begin
          w_dpop = 1'b1;
          w_beat = 1'b1;
          if (w_last) begin
            if (w_head.ie) begin
              w_state_nxt = SKIP_END;
            end else begin
              w_tpop      = 1'b1;
              w_state_nxt = w_follow;
            end
          end
        end
      end
      SKIP_END: begin
        if (!w_dempty) begin
          w_dpop      = 1'b1;
          w_tpop      = 1'b1;
          w_state_nxt = w_follow;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Beat index within the current burst
  always_ff @(posedge clk) begin
    if (reset)       r_beat_cnt <= '0;
    else if (w_beat) r_beat_cnt <= w_last ? 8'd0 : r_beat_cnt + 8'd1;
  end

  // Registered R output slot; holds while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
    end else if (w_slot_free) begin
      r_rvalid <= w_beat;
      if (w_beat) begin
        r_rid   <= w_head.id;
        r_rdata <= r_dmem[r_drd];
        r_rlast <= w_last;
      end
    end
  end

  assign rvalid       = r_rvalid;
  assign rlast        = r_rlast;
  assign rid          = r_rid;
  assign rdata        = r_rdata;
  assign rresp        = 2'b00;
  assign overflow_err = r_ovf;

endmodule
